mem_access_stage: RTL and testbench

- Memory-access pipeline stage directly upstream of the write-back mux.
- Takes execute results, runs loads and stores against data memory with a req/ack handshake, and sign- or zero-extends load data.
- Registers alu_result, mem_data, mem_to_reg, reg_write and rd for the write-back stage.
- Stalls upstream while a memory transaction is outstanding.

---
 rtl/mem_pkg.sv | 18 +
 rtl/load_store_align.sv | 58 +++++
 rtl/mem_access_stage.sv | 204 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 access codes,
// the stage FSM encoding and the default datapath width.
package mem_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering: replicates store data across lanes with
// matching byte enables, and extracts/extends the addressed lane of a load word.
module load_store_align
  import mem_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Only addr[1] picks the half; addr[0] is deliberately ignored here.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wdata = store_data;
    wstrb = 4'b1111;
    case (funct3)
      F3_B: begin
        wdata = {(XLEN/8){store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      F3_H: begin
        wdata = {(XLEN/16){store_data[15:0]}};
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues load/store requests with a req/ack
// handshake and registers results for write-back. Optional MEM_MISALIGN_TRAP_EN.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] store_data,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic            mem_to_reg_in,
  input  logic            reg_write_in,
  input  logic [RD_W-1:0] rd_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] mem_data,
  output logic            mem_to_reg,
  output logic            reg_write,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic            misalign_err,
`endif
  output logic [RD_W-1:0] rd
);

  mem_state_t      state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic            is_load_q, is_load_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] mem_data_q, mem_data_d;
  logic            mem_to_reg_q, mem_to_reg_d;
  logic            reg_write_q, reg_write_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            misalign_q, misalign_d;

  logic            misaligned;
  logic [2:0]      align_funct3;
  logic [1:0]      align_addr_lo;
  logic [XLEN-1:0] align_wdata;
  logic [3:0]      align_wstrb;
  logic [XLEN-1:0] align_load;

  // The aligner serves the incoming op when idle and the held op while busy.
  assign align_funct3  = (state_q == IDLE) ? funct3 : funct3_q;
  assign align_addr_lo = (state_q == IDLE) ? alu_result_in[1:0] : addr_lo_q;

  load_store_align #(.XLEN(XLEN)) u_align (
    .funct3     (align_funct3),
    .addr_lo    (align_addr_lo),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .wdata      (align_wdata),
    .wstrb      (align_wstrb),
    .load_data  (align_load)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && alu_result_in[0]) ||
                 ((funct3 == F3_W) && (alu_result_in[1:0] != 2'b00));
  end
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    is_load_d    = is_load_q;
    wb_valid_d   = 1'b0;
    alu_d        = alu_q;
    mem_data_d   = mem_data_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    rd_d         = rd_q;
    misalign_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          alu_d        = alu_result_in;
          mem_to_reg_d = mem_to_reg_in;
          reg_write_d  = reg_write_in;
          rd_d         = rd_in;
          mem_data_d   = '0;
          if (!(mem_read || mem_write)) begin
            wb_valid_d = 1'b1;
          end else if (misaligned) begin
            wb_valid_d  = 1'b1;
            reg_write_d = 1'b0;
            misalign_d  = 1'b1;
          end else begin
            // A simultaneous read+write is issued purely as a store.
            state_d   = BUSY;
            req_d     = 1'b1;
            we_d      = mem_write;
            addr_d    = {alu_result_in[XLEN-1:2], 2'b00};
            wdata_d   = mem_write ? align_wdata : '0;
            wstrb_d   = mem_write ? align_wstrb : 4'b0000;
            funct3_d  = funct3;
            addr_lo_d = alu_result_in[1:0];
            is_load_d = mem_read && !mem_write;
          end
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          we_d       = 1'b0;
          wstrb_d    = 4'b0000;
          wb_valid_d = 1'b1;
          mem_data_d = is_load_q ? align_load : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= 4'b0000;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      is_load_q    <= 1'b0;
      wb_valid_q   <= 1'b0;
      alu_q        <= '0;
      mem_data_q   <= '0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      is_load_q    <= is_load_d;
      wb_valid_q   <= wb_valid_d;
      alu_q        <= alu_d;
      mem_data_q   <= mem_data_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      misalign_q   <= misalign_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;
  assign wb_valid   = wb_valid_q;
  assign alu_result = alu_q;
  assign mem_data   = mem_data_q;
  assign mem_to_reg = mem_to_reg_q;
  // reg_write is held internally but only presented during the WB pulse.
  assign reg_write  = reg_write_q && wb_valid_q;
  assign rd         = rd_q;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_err = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scoreboard bench for mem_access_stage: expected WB results are queued
// when an instruction is driven and compared when wb_valid pulses.
module tb_mem_access_stage;

   typedef struct {
      logic [31:0] aluResult;
      logic [31:0] memData;
      logic        memToReg;
      logic        regWrite;
      logic [4:0]  rdIdx;
   } expect_t;

   logic        clk;
   logic        rst;
   logic        inValid;
   logic        inReady;
   logic [31:0] aluResultIn;
   logic [31:0] storeData;
   logic        memRead;
   logic        memWrite;
   logic [2:0]  funct3;
   logic        memToRegIn;
   logic        regWriteIn;
   logic [4:0]  rdIn;
   logic        dmemReq;
   logic        dmemWe;
   logic [31:0] dmemAddr;
   logic [31:0] dmemWdata;
   logic [3:0]  dmemWstrb;
   logic        dmemAck;
   logic [31:0] dmemRdata;
   logic        wbValid;
   logic [31:0] aluResult;
   logic [31:0] memData;
   logic        memToReg;
   logic        regWrite;
   logic [4:0]  rd;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalignErr;
`endif

   expect_t     scoreboard[$];
   int          checkCount = 0;
   int          passCount  = 0;
   int          failCount  = 0;
   logic [31:0] lastMemData = 32'h0;

   mem_access_stage #(.XLEN(32), .RD_W(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (inValid),
      .in_ready      (inReady),
      .alu_result_in (aluResultIn),
      .store_data    (storeData),
      .mem_read      (memRead),
      .mem_write     (memWrite),
      .funct3        (funct3),
      .mem_to_reg_in (memToRegIn),
      .reg_write_in  (regWriteIn),
      .rd_in         (rdIn),
      .dmem_req      (dmemReq),
      .dmem_we       (dmemWe),
      .dmem_addr     (dmemAddr),
      .dmem_wdata    (dmemWdata),
      .dmem_wstrb    (dmemWstrb),
      .dmem_ack      (dmemAck),
      .dmem_rdata    (dmemRdata),
      .wb_valid      (wbValid),
      .alu_result    (aluResult),
      .mem_data      (memData),
      .mem_to_reg    (memToReg),
      .reg_write     (regWrite),
`ifdef MEM_MISALIGN_TRAP_EN
      .misalign_err  (misalignErr),
`endif
      .rd            (rd)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts passes and failures and reports mismatches.
   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drives one instruction at a negedge, queues its WB result, and returns at the
   // negedge after the accepting edge with in_valid dropped.
   task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] sd, input logic mr,
                                input logic mw, input logic [2:0] f3, input logic mtr,
                                input logic rw, input logic [4:0] rdi, input logic [31:0] expMem,
                                input logic expRw);
      expect_t e;
      checkValue("in_ready before accept", {31'b0, inReady}, 32'd1);
      inValid     = 1'b1;
      aluResultIn = alu;
      storeData   = sd;
      memRead     = mr;
      memWrite    = mw;
      funct3      = f3;
      memToRegIn  = mtr;
      regWriteIn  = rw;
      rdIn        = rdi;
      e.aluResult = alu;
      e.memData   = expMem;
      e.memToReg  = mtr;
      e.regWrite  = expRw;
      e.rdIdx     = rdi;
      scoreboard.push_back(e);
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
   endtask

   // Expects a WB pulse now and compares it with the oldest queued result.
   task automatic checkOutput(input string tag);
      expect_t e;
      checkValue({tag, " wb_valid"}, {31'b0, wbValid}, 32'd1);
      if (scoreboard.size() == 0) begin
         checkCount++;
         failCount++;
         $error("[TB] FAIL %s scoreboard: observed empty queue expected an entry", tag);
      end else begin
         e = scoreboard.pop_front();
         checkValue({tag, " alu_result"}, aluResult, e.aluResult);
         checkValue({tag, " mem_data"}, memData, e.memData);
         checkValue({tag, " mem_to_reg"}, {31'b0, memToReg}, {31'b0, e.memToReg});
         checkValue({tag, " reg_write"}, {31'b0, regWrite}, {31'b0, e.regWrite});
         checkValue({tag, " rd"}, {27'b0, rd}, {27'b0, e.rdIdx});
         lastMemData = e.memData;
      end
   endtask

   // Plays the memory side: holds ack low for 'waits' request cycles, then acks.
   task automatic memTransaction(input string tag, input int waits, input logic [31:0] rdata,
                                 input logic [31:0] expAddr, input logic expWe,
                                 input logic [31:0] expWdata, input logic [3:0] expWstrb);
      int lowReady = 0;
      for (int i = 0; i <= waits; i++) begin
         checkValue({tag, " dmem_req"}, {31'b0, dmemReq}, 32'd1);
         checkValue({tag, " dmem_addr"}, dmemAddr, expAddr);
         checkValue({tag, " dmem_we"}, {31'b0, dmemWe}, {31'b0, expWe});
         checkValue({tag, " dmem_wstrb"}, {28'b0, dmemWstrb}, {28'b0, expWstrb});
         if (expWe) checkValue({tag, " dmem_wdata"}, dmemWdata, expWdata);
         checkValue({tag, " wb_valid busy"}, {31'b0, wbValid}, 32'd0);
         if (!inReady) lowReady++;
         if (i == waits) begin
            dmemAck   = 1'b1;
            dmemRdata = rdata;
         end
         @(posedge clk);
         @(negedge clk);
         dmemAck   = 1'b0;
         dmemRdata = $urandom;
      end
      checkValue({tag, " in_ready low cycles"}, lowReady, waits + 1);
      checkValue({tag, " dmem_req after ack"}, {31'b0, dmemReq}, 32'd0);
      checkOutput(tag);
   endtask

   initial begin
      rst = 1'b0; inValid = 1'b0; aluResultIn = '0; storeData = '0; memRead = 1'b0;
      memWrite = 1'b0; funct3 = 3'b000; memToRegIn = 1'b0; regWriteIn = 1'b0; rdIn = '0;
      dmemAck = 1'b0; dmemRdata = '0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      checkValue("reset dmem_req", {31'b0, dmemReq}, 32'd0);
      checkValue("reset wb_valid", {31'b0, wbValid}, 32'd0);
      checkValue("reset alu_result", aluResult, 32'd0);
      checkValue("reset mem_data", memData, 32'd0);
      checkValue("reset reg_write", {31'b0, regWrite}, 32'd0);
      checkValue("reset dmem_wstrb", {28'b0, dmemWstrb}, 32'd0);
      checkValue("reset in_ready", {31'b0, inReady}, 32'd1);
      rst = 1'b0;
      @(negedge clk);

      // ALU op, then the pulse must end and reg_write be gated while fields hold
      applyStimulus(32'h1234, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 5'd5, 32'h0, 1'b1);
      checkValue("alu dmem_req", {31'b0, dmemReq}, 32'd0);
      checkOutput("alu");
      @(negedge clk);
      checkValue("alu pulse end", {31'b0, wbValid}, 32'd0);
      checkValue("alu reg_write gated", {31'b0, regWrite}, 32'd0);
      checkValue("alu field held", aluResult, 32'h1234);

      applyStimulus(32'h1003, 32'h0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 5'd6, 32'hFFFF_FF80, 1'b1);
      memTransaction("lb", 0, 32'h80FF_0000, 32'h1000, 1'b0, 32'h0, 4'b0000);

      applyStimulus(32'h2002, 32'h0, 1'b1, 1'b0, 3'b101, 1'b1, 1'b1, 5'd7, 32'h0000_BEEF, 1'b1);
      memTransaction("lhu", 3, 32'hBEEF_1234, 32'h2000, 1'b0, 32'h0, 4'b0000);

      applyStimulus(32'h3001, 32'hAB, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      memTransaction("sb", 2, 32'hDEAD_DEAD, 32'h3000, 1'b1, 32'hABAB_ABAB, 4'b0010);

      applyStimulus(32'h5002, 32'h0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 5'd8, 32'hFFFF_8001, 1'b1);
      memTransaction("lh", 1, 32'h8001_7FFF, 32'h5000, 1'b0, 32'h0, 4'b0000);

      applyStimulus(32'h6002, 32'h1234_CAFE, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      memTransaction("sh", 0, 32'h0, 32'h6000, 1'b1, 32'hCAFE_CAFE, 4'b1100);

      applyStimulus(32'h7000, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      memTransaction("sw", 1, 32'h0, 32'h7000, 1'b1, 32'hDEAD_BEEF, 4'b1111);

      applyStimulus(32'h8000, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 5'd9, 32'h1234_5678, 1'b1);
      memTransaction("lw", 0, 32'h1234_5678, 32'h8000, 1'b0, 32'h0, 4'b0000);

      applyStimulus(32'h8001, 32'h0, 1'b1, 1'b0, 3'b100, 1'b1, 1'b1, 5'd10, 32'h0000_009A, 1'b1);
      memTransaction("lbu", 0, 32'h12F0_9A56, 32'h8000, 1'b0, 32'h0, 4'b0000);

      // Read and write together behave as a store with zero mem_data
      applyStimulus(32'h9000, 32'h55AA_55AA, 1'b1, 1'b1, 3'b010, 1'b1, 1'b1, 5'd11, 32'h0, 1'b1);
      memTransaction("rw both", 0, 32'hFFFF_FFFF, 32'h9000, 1'b1, 32'h55AA_55AA, 4'b1111);

`ifndef MEM_MISALIGN_TRAP_EN
      applyStimulus(32'h5003, 32'h0, 1'b1, 1'b0, 3'b101, 1'b1, 1'b1, 5'd12, 32'h0000_1234, 1'b1);
      memTransaction("lhu off3", 0, 32'h1234_5678, 32'h5000, 1'b0, 32'h0, 4'b0000);
`else
      applyStimulus(32'h4002, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 5'd13, 32'h0, 1'b0);
      checkValue("misalign dmem_req", {31'b0, dmemReq}, 32'd0);
      checkValue("misalign_err", {31'b0, misalignErr}, 32'd1);
      checkOutput("misalign lw");
`endif

      // A stray ack while idle must not produce a WB pulse or change mem_data
      @(negedge clk);
      dmemAck = 1'b1; dmemRdata = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      dmemAck = 1'b0;
      checkValue("idle ack wb_valid", {31'b0, wbValid}, 32'd0);
      checkValue("idle ack dmem_req", {31'b0, dmemReq}, 32'd0);
      checkValue("idle ack mem_data held", memData, lastMemData);

      // Back-to-back ALU ops complete every cycle
      applyStimulus(32'hA1, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 5'd1, 32'h0, 1'b1);
      checkOutput("b2b first");
      applyStimulus(32'hA2, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 5'd2, 32'h0, 1'b1);
      checkOutput("b2b second");

      // Reset in the middle of a transaction drops it
      applyStimulus(32'hA000, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 5'd3, 32'h0, 1'b1);
      checkValue("busy dmem_req", {31'b0, dmemReq}, 32'd1);
      rst = 1'b1;
      #1;
      checkValue("busy reset dmem_req", {31'b0, dmemReq}, 32'd0);
      checkValue("busy reset wb_valid", {31'b0, wbValid}, 32'd0);
      checkValue("busy reset reg_write", {31'b0, regWrite}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      scoreboard.delete();
      @(negedge clk);
      checkValue("post reset in_ready", {31'b0, inReady}, 32'd1);
      applyStimulus(32'h4321, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 5'd4, 32'h0, 1'b1);
      checkOutput("post reset alu");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
